// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
//   Shared types and constants for the data-memory responder slice:
//   FSM state encoding, response-data source select, bus widths, the
//   rsp_err encoding and the placement of the optional MMIO register.
//   Optional feature macro used by the slice: DMEM_MMIO_EN.
// ---------------------------------------------------------------------------
package data_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    // Wait-state counter width; covers WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    // Which source feeds rsp_rdata after a response.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_RAM,
        SRC_MMIO
    } rsp_src_t;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    // The MMIO register sits this many words past BASE_ADDR, i.e. the
    // first word after the RAM.
    function automatic int unsigned mmio_offset_words(input int unsigned depth);
        return depth;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Load/store request/response bundle between the core datapath (master)
//   and the data-memory responder (slave).
//   Signals:
//     req_valid  master->slave  request present
//     req_write  master->slave  1 = store, 0 = load
//     req_addr   master->slave  byte address
//     req_wdata  master->slave  store data
//     req_ready  slave->master  responder can accept this cycle
//     rsp_valid  slave->master  one-cycle response strobe
//     rsp_rdata  slave->master  load data (0 for stores and errors)
//     rsp_err    slave->master  misaligned / out-of-range, valid with rsp_valid
// ---------------------------------------------------------------------------
interface data_mem_responder_if
    import data_mem_pkg::*;
();

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_array.sv
// ---------------------------------------------------------------------------
// data_mem_array
//   Synchronous single-port word RAM, DEPTH x DATA_W.
//   Ports:
//     clk    clock
//     en     access enable (one access per enabled edge)
//     we     1 = write wdata, 0 = read into rdata
//     addr   word index
//     wdata  write data
//     rdata  registered read data; holds until the next enabled read
// ---------------------------------------------------------------------------
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array and its read register have no reset so the
    // array maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the core's load/store interface. Accepts one request
//   at a time, waits WAIT_CYCLES, performs a single RAM access, then pulses
//   rsp_valid for one cycle with rsp_rdata / rsp_err.
//   Parameters:
//     DEPTH        words of RAM (power of two, >= 4)
//     WAIT_CYCLES  wait states between accept and access (0..15)
//     BASE_ADDR    byte address of word 0 (DEPTH*4 aligned)
//   Ports:
//     clk      system clock, rising edge
//     rst      asynchronous, active-high reset
//     bus      data_mem_responder_if.slave request/response bundle
//     led_out  8-bit output register (only with DMEM_MMIO_EN)
//   Optional feature macro: DMEM_MMIO_EN -- adds an 8-bit output register
//   at word address BASE_ADDR + DEPTH*4, readable and writable.
// ---------------------------------------------------------------------------
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned       DEPTH       = 256,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
`ifdef DMEM_MMIO_EN
    ,
    output logic [7:0]           led_out
`endif
);

    localparam int unsigned       AW        = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] RAM_BYTES = ADDR_W'(DEPTH * 4);
    localparam logic [CNT_W-1:0]  WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              hold_write;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;

    logic              ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    rsp_src_t          src_q;

    // ---------------------------------------------------------------------
    // Address decode of the held request (used only in ACCESS)
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0] offset;
    logic              misaligned;
    logic              in_ram;
    logic              is_mmio;
    logic              dec_err;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far
    // above RAM_BYTES and decode as out of range.
    assign offset     = hold_addr - BASE_ADDR;
    assign misaligned = |hold_addr[1:0];
    assign in_ram     = offset < RAM_BYTES;

`ifdef DMEM_MMIO_EN
    localparam logic [ADDR_W-1:0] MMIO_OFFSET_BYTES =
        ADDR_W'(mmio_offset_words(DEPTH) * 4);
    assign is_mmio = (offset == MMIO_OFFSET_BYTES);
`else
    assign is_mmio = 1'b0;
`endif

    assign dec_err = misaligned || !(in_ram || is_mmio);

    // ---------------------------------------------------------------------
    // RAM
    // ---------------------------------------------------------------------
    logic              ram_en;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // The RAM is only touched on the ACCESS edge, so its read register
    // keeps the last load's data until the next load reaches ACCESS.
    assign ram_en   = (state == ACCESS) && !misaligned && in_ram;
    assign ram_we   = ram_en && hold_write;
    assign ram_addr = offset[AW+1:2];

    data_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (hold_wdata),
        .rdata (ram_rdata)
    );

    // ---------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // ---------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all state updates
    // see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hold_write  <= 1'b0;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= RSP_OK;
            src_q       <= SRC_ZERO;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready_q && bus.req_valid) begin
                        hold_write <= bus.req_write;
                        hold_addr  <= bus.req_addr;
                        hold_wdata <= bus.req_wdata;
                        ready_q    <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end else begin
                            state <= ACCESS;
                        end
                    end else begin
                        // First cycle after reset raises ready here.
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= dec_err ? RSP_ERR : RSP_OK;
                    if (dec_err || hold_write) begin
                        src_q <= SRC_ZERO;
                    end else if (is_mmio) begin
                        src_q <= SRC_MMIO;
                    end else begin
                        src_q <= SRC_RAM;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Optional MMIO output register
    // ---------------------------------------------------------------------
`ifdef DMEM_MMIO_EN
    logic [7:0] led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= '0;
        end else if ((state == ACCESS) && is_mmio && !misaligned && hold_write) begin
            led_q <= hold_wdata[7:0];
        end
    end

    assign led_out = led_q;
`endif

    // ---------------------------------------------------------------------
    // Response data select
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] rsp_rdata;

    // NOTE: default assignment first so no path leaves rsp_rdata unassigned
    // (which would infer a latch).
    always_comb begin
        rsp_rdata = '0;
        case (src_q)
            SRC_RAM:  rsp_rdata = ram_rdata;
`ifdef DMEM_MMIO_EN
            SRC_MMIO: rsp_rdata = {24'b0, led_q};
`endif
            default:  rsp_rdata = '0;
        endcase
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's load/store interface.
- Accepts one request at a time from the datapath:
  - byte address, taken from ALUResult
  - store data, taken from WriteData
  - write flag
- Services the request from an internal word RAM after a programmable number of wait states, then returns load data (ReadData) with a one-cycle response strobe.
- Sits between the single-cycle/multicycle core and on-chip data storage; the core stalls on req_ready/rsp_valid.

Parameters:
- DEPTH, 256: number of 32-bit words in the RAM; power of two, ≥4.
- WAIT_CYCLES, 1: wait states between accept and RAM access; range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range; valid with rsp_valid.
- led_out  out  8  only present with DMEM_MMIO_EN.

Behaviour:
- Reset (async): state=IDLE; req_ready=0 while rst is high, then 1; rsp_valid=0; rsp_rdata=0; rsp_err=0; counter=0; held request cleared. RAM contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch addr, wdata and write flag (accept). Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
  - WAIT: counter loads WAIT_CYCLES-1 on accept and decrements each cycle; at 0 go to ACCESS. req_ready=0.
  - ACCESS: one cycle.
    - Decode the held address.
    - Store: RAM write at the clock edge.
    - Load: registered RAM read into rsp_rdata.
    - Go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, rsp_err per decode; next state is IDLE.
- req_ready=0 in WAIT, ACCESS and RESP; req_valid is ignored there and is not queued.
- Latency: the accept edge is T; rsp_valid is high in cycle T+WAIT_CYCLES+2. Back-to-back throughput is one request per WAIT_CYCLES+3 cycles.
- Decode:
  - Offset = addr - BASE_ADDR, 32-bit unsigned wrap.
  - Index = offset[log2(DEPTH)+1:2].
  - Error if addr[1:0]!=0 or offset ≥ DEPTH*4.
  - On error: no RAM write, rsp_rdata=0, rsp_err=1.
- rsp_rdata and rsp_err hold their value after RESP until the next RESP; they are only meaningful while rsp_valid=1.
- Read-after-write to the same word in consecutive requests returns the new data (the write commits before the next accept).
- Reset mid-operation:
  - Aborts to IDLE.
  - A store whose ACCESS edge has not occurred is dropped.
  - A store already written is kept.
  - No rsp_valid is issued for the aborted request.
- Request fields are sampled only at accept; later changes to the inputs have no effect.

Optional Feature:
- Macro DMEM_MMIO_EN.
- With the macro:
  - The led_out port exists.
  - Word address BASE_ADDR+DEPTH*4 is an 8-bit output register: a store sets led_out=wdata[7:0], a load returns {24'b0, led_out}, rsp_err=0.
  - led_out resets to 0.
- Without the macro: no port; that address decodes as out of range (rsp_err=1).

Decomposition:
- Package data_mem_pkg:
  - state enum (IDLE, WAIT, ACCESS, RESP)
  - DATA_W=32, ADDR_W=32
  - MMIO_OFFSET_WORDS (=DEPTH, applied as offset)
  - rsp_err encoding constant
- One sub-module: data_mem_array, a synchronous single-port RAM (DEPTH×32; we, addr, wdata, registered rdata). The FSM, counter, decode and MMIO register stay in the top level.

Test Plan:
1. Reset with WAIT_CYCLES=1 → req_ready=1, rsp_valid=0, rsp_rdata=0 one cycle after rst falls. Store 32'hDEAD_BEEF to 0x10, accept at T → rsp_valid at T+3, rsp_err=0. Then load 0x10 → rsp_rdata=32'hDEAD_BEEF.
2. WAIT_CYCLES=0 and WAIT_CYCLES=3 builds: load accepted at T → rsp_valid exactly at T+2 and T+5 respectively; req_ready=0 throughout, and req_valid held high is not accepted twice.
3. Boundaries with DEPTH=256: store to 0x3FC (last word) then load → data returned. Load 0x400 → rsp_err=1, rsp_rdata=0. Store to 0x402 (misaligned) → rsp_err=1, and a subsequent load of 0x400-aligned word 0x3FC is unchanged.
4. Reset mid-operation: store 0x1234_5678 to 0x20 with WAIT_CYCLES=3, assert rst in the second WAIT cycle → no rsp_valid. After reset, a load of 0x20 returns the previous value.
5. Back-to-back: store A then load A with no idle cycle after RESP → new value returned; the second accept happens in the cycle after rsp_valid.
6. DMEM_MMIO_EN, DEPTH=256: store 32'h0000_00A5 to 0x400 → led_out=8'hA5, rsp_err=0; load 0x400 → rsp_rdata=32'h0000_00A5. Without the macro, the same store → rsp_err=1.
